// File: rtl/simon_control.sv
// rtl/simon_control.sv - Simon game control FSM: step sync, playback pacing, datapath strobes
module simon_control #(
  parameter int PLAY_TICKS = 4,
  parameter int TIMER_W    = 26,
  parameter int MAX_LEN    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       seq_remain,
  input  logic       valid_repeat,
  input  logic       valid_input,
  output logic       clear_i,
  output logic       increment_i,
  output logic       increment_n,
  output logic       write_pattern,
  output logic       input_led_pattern,
  output logic [2:0] mode_leds
);

  localparam int                 LEN_W     = $clog2(MAX_LEN) + 1;
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(PLAY_TICKS - 1);
  localparam logic [LEN_W-1:0]   LEN_FULL  = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_INPUT,
    S_PLAYBACK,
    S_REPEAT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               s1_q, s2_q, s3_q;
  logic               step_pulse;
  logic               last_tick;

  // s1/s2 resolve metastability on the raw button; s3 delays s2 for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= step;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign step_pulse = s2_q & ~s3_q;
  assign last_tick  = (timer_q == LAST_TICK);

  always_comb begin
    state_d           = state_q;
    len_d             = len_q;
    timer_d           = timer_q;
    clear_i           = 1'b0;
    increment_i       = 1'b0;
    increment_n       = 1'b0;
    write_pattern     = 1'b0;
    input_led_pattern = 1'b1;
    mode_leds         = 3'b001;

    case (state_q)
      S_INPUT: begin
        input_led_pattern = 1'b1;
        mode_leds         = 3'b001;
        timer_d           = '0;
        if (step_pulse && valid_input) begin
          clear_i = 1'b1;
          // a full memory still replays the existing sequence, just without growing it
          if (len_q < LEN_FULL) begin
            write_pattern = 1'b1;
            increment_n   = 1'b1;
            len_d         = len_q + 1'b1;
          end
          state_d = S_PLAYBACK;
        end
      end

      S_PLAYBACK: begin
        input_led_pattern = 1'b0;
        mode_leds         = 3'b010;
        if (last_tick) begin
          timer_d = '0;
          if (seq_remain) begin
            increment_i = 1'b1;
          end else begin
            clear_i = 1'b1;
            state_d = S_REPEAT;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_REPEAT: begin
        input_led_pattern = 1'b1;
        mode_leds         = 3'b100;
        timer_d           = '0;
        if (step_pulse) begin
          if (!valid_repeat) begin
            clear_i = 1'b1;
            state_d = S_DONE;
          end else if (seq_remain) begin
            increment_i = 1'b1;
          end else begin
            clear_i = 1'b1;
            state_d = S_INPUT;
          end
        end
      end

      S_DONE: begin
        input_led_pattern = 1'b0;
        mode_leds         = 3'b111;
        // loops the stored sequence forever; only reset leaves this state
        if (last_tick) begin
          timer_d = '0;
          if (seq_remain) begin
            increment_i = 1'b1;
          end else begin
            clear_i = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = S_INPUT;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INPUT;
      len_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_simon_control.sv
// tb/tb_simon_control.sv - vector table and scoreboard bench for simon_control
module tb_simon_control;

  localparam logic [7:0] E_IN   = 8'b0000_1_001;
  localparam logic [7:0] WR_ALL = 8'b1011_1_001;
  localparam logic [7:0] IN_CLR = 8'b1000_1_001;
  localparam logic [7:0] E_PB   = 8'b0000_0_010;
  localparam logic [7:0] PB_INC = 8'b0100_0_010;
  localparam logic [7:0] PB_CLR = 8'b1000_0_010;
  localparam logic [7:0] E_RP   = 8'b0000_1_100;
  localparam logic [7:0] RP_INC = 8'b0100_1_100;
  localparam logic [7:0] RP_CLR = 8'b1000_1_100;
  localparam logic [7:0] E_DN   = 8'b0000_0_111;
  localparam logic [7:0] DN_INC = 8'b0100_0_111;
  localparam logic [7:0] DN_CLR = 8'b1000_0_111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step = 1'b0;
  logic       seq_remain = 1'b0;
  logic       valid_repeat = 1'b0;
  logic       valid_input = 1'b0;
  logic       clear_i, increment_i, increment_n, write_pattern, input_led_pattern;
  logic [2:0] mode_leds;

  typedef struct {
    logic       st;
    logic       vi;
    logic       vr;
    logic       sr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  sb_t  mon_e;
  int   checks = 0;
  int   errors = 0;

  wire [7:0] got = {clear_i, increment_i, increment_n, write_pattern,
                    input_led_pattern, mode_leds};

  simon_control #(.PLAY_TICKS(4), .TIMER_W(26), .MAX_LEN(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .step             (step),
    .seq_remain       (seq_remain),
    .valid_repeat     (valid_repeat),
    .valid_input      (valid_input),
    .clear_i          (clear_i),
    .increment_i      (increment_i),
    .increment_n      (increment_n),
    .write_pattern    (write_pattern),
    .input_led_pattern(input_led_pattern),
    .mode_leds        (mode_leds)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [7:0] g, input logic [7:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got clr/inci/incn/wr/ilp/mode=%b expected %b", name, g, e);
    end
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.name, got, mon_e.exp);
    end
  end

  task automatic cyc(input logic st, input logic vi, input logic vr, input logic sr,
                     input logic [7:0] e, input string name);
    @(posedge clk);
    #1;
    step         = st;
    valid_input  = vi;
    valid_repeat = vr;
    seq_remain   = sr;
    sb_q.push_back('{exp: e, name: name});
  endtask

  task automatic add(input int n, input logic st, input logic vi, input logic vr,
                     input logic sr, input logic [7:0] e, input string name);
    repeat (n) vecs.push_back('{st: st, vi: vi, vr: vr, sr: sr, exp: e, name: name});
  endtask

  initial begin
    add(1, 0, 0, 0, 0, E_IN,   "idle");
    add(3, 1, 0, 0, 0, E_IN,   "illegal_input_ignored");
    add(2, 0, 0, 0, 0, E_IN,   "illegal_release");
    add(1, 0, 1, 0, 0, E_IN,   "idle_valid");
    add(2, 1, 1, 0, 0, E_IN,   "step_sync_delay");
    add(1, 1, 1, 0, 0, WR_ALL, "input_write");
    add(3, 1, 1, 0, 1, E_PB,   "pb_show_1");
    add(1, 1, 1, 0, 1, PB_INC, "pb_inc_i_1");
    add(3, 1, 1, 0, 1, E_PB,   "pb_show_2");
    add(1, 1, 1, 0, 1, PB_INC, "pb_inc_i_2");
    add(3, 1, 1, 0, 0, E_PB,   "pb_show_3");
    add(1, 1, 1, 0, 0, PB_CLR, "pb_clear_to_repeat");
    add(7, 1, 1, 1, 1, E_RP,   "repeat_held_step");
    add(2, 0, 1, 1, 1, E_RP,   "repeat_release");
    add(2, 1, 1, 1, 1, E_RP,   "repeat_wait_1");
    add(1, 1, 1, 1, 1, RP_INC, "repeat_inc_i");
    add(2, 0, 1, 1, 1, E_RP,   "repeat_release_2");
    add(2, 1, 1, 1, 0, E_RP,   "repeat_wait_2");
    add(1, 1, 1, 1, 0, RP_CLR, "repeat_win");
    add(2, 0, 1, 0, 0, E_IN,   "back_to_input");
    add(2, 1, 1, 0, 0, E_IN,   "input_wait_2");
    add(1, 1, 1, 0, 0, WR_ALL, "input_write_2");
    add(3, 0, 1, 0, 0, E_PB,   "pb_single_show");
    add(1, 0, 1, 0, 0, PB_CLR, "pb_single_entry");
    add(2, 0, 1, 0, 0, E_RP,   "repeat_idle");
    add(2, 1, 0, 0, 0, E_RP,   "repeat_wait_3");
    add(1, 1, 0, 0, 0, RP_CLR, "repeat_fail");
    add(1, 0, 0, 0, 0, E_DN,   "done_show_1");
    add(2, 1, 0, 0, 0, E_DN,   "done_step_ignored");
    add(1, 1, 0, 0, 0, DN_CLR, "done_clear_1");
    add(2, 1, 0, 0, 0, E_DN,   "done_show_2");
    add(1, 0, 0, 0, 0, E_DN,   "done_show_3");
    add(1, 0, 0, 0, 0, DN_CLR, "done_clear_2");
    add(3, 0, 0, 0, 1, E_DN,   "done_show_4");
    add(1, 0, 0, 0, 1, DN_INC, "done_inc_i");
    add(3, 0, 0, 0, 0, E_DN,   "done_show_5");
    add(1, 0, 0, 0, 0, DN_CLR, "done_clear_3");

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", got, E_IN);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++)
      cyc(vecs[k].st, vecs[k].vi, vecs[k].vr, vecs[k].sr, vecs[k].exp, vecs[k].name);
    @(negedge clk);

    @(posedge clk);
    #3;
    rst  = 1'b0;
    step = 1'b0;
    #1;
    check("async_reset_from_done", got, E_IN);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int r = 0; r <= 64; r++) begin
      cyc(1, 1, 1, 0, E_IN, "cap_pre");
      cyc(1, 1, 1, 0, E_IN, "cap_pre");
      cyc(1, 1, 1, 0, (r < 64) ? WR_ALL : IN_CLR, (r < 64) ? "cap_write" : "cap_full_clear_only");
      cyc(0, 1, 1, 0, E_PB, "cap_pb");
      cyc(0, 1, 1, 0, E_PB, "cap_pb");
      if (r == 64) break;
      cyc(0, 1, 1, 0, E_PB, "cap_pb");
      cyc(0, 1, 1, 0, PB_CLR, "cap_pb_clear");
      cyc(1, 1, 1, 0, E_RP, "cap_rp");
      cyc(1, 1, 1, 0, E_RP, "cap_rp");
      cyc(1, 1, 1, 0, RP_CLR, "cap_repeat_win");
      cyc(0, 1, 1, 0, E_IN, "cap_input");
    end
    @(negedge clk);

    @(posedge clk);
    #3;
    rst  = 1'b0;
    step = 1'b0;
    #1;
    check("async_reset_mid_playback", got, E_IN);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", got, E_IN);
    rst = 1'b1;

    cyc(1, 1, 0, 0, E_IN, "post_reset_idle");
    cyc(1, 1, 0, 0, E_IN, "post_reset_idle");
    cyc(1, 1, 0, 0, WR_ALL, "post_reset_len_cleared");
    cyc(0, 1, 0, 0, E_PB, "post_reset_playback");
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
